// File: rtl/senseedge_run_sequencer.sv
// SenseEdge run sequencer: captures a decimated sample frame, launches FFT then NN
// with per-engine timeouts, latches the class and raises a sticky interrupt.
module senseedge_run_sequencer #(
    parameter int N_SAMPLES = 256,
    parameter int SAMPLE_W  = 16,
    parameter int AW        = $clog2(N_SAMPLES)
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic                cfg_enable_i,
    input  logic                cfg_continuous_i,
    input  logic                cfg_start_i,
    input  logic                cfg_abort_i,
    input  logic [7:0]          cfg_decimate_i,
    input  logic [15:0]         cfg_timeout_i,
    input  logic                smp_valid_i,
    input  logic [SAMPLE_W-1:0] smp_data_i,
    output logic                buf_we_o,
    output logic [AW-1:0]       buf_addr_o,
    output logic [SAMPLE_W-1:0] buf_wdata_o,
    output logic                fft_start_o,
    input  logic                fft_done_i,
    output logic                nn_start_o,
    input  logic                nn_done_i,
    input  logic [3:0]          nn_class_i,
    input  logic                irq_clr_i,
    output logic                busy_o,
    output logic [2:0]          state_o,
    output logic                result_valid_o,
    output logic [3:0]          result_class_o,
    output logic                err_o,
    output logic [1:0]          err_code_o,
    output logic                irq_o,
    output logic [15:0]         run_count_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_FFT     = 3'd2,
        ST_NN      = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    localparam logic [AW:0] IDX_ONE = {{AW{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [AW:0]           idx_q, idx_d;
    logic [7:0]            dec_q, dec_d;
    logic [15:0]           tmr_q, tmr_d;
    logic                  tmo_en_q, tmo_en_d;
    logic                  buf_we_q, buf_we_d;
    logic [AW-1:0]         buf_addr_q, buf_addr_d;
    logic [SAMPLE_W-1:0]   buf_wdata_q, buf_wdata_d;
    logic                  fft_start_q, fft_start_d;
    logic                  nn_start_q, nn_start_d;
    logic                  busy_q, busy_d;
    logic                  res_valid_q, res_valid_d;
    logic [3:0]            res_class_q, res_class_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  irq_q, irq_d;
    logic [15:0]           run_cnt_q, run_cnt_d;

    logic abort;
    logic tmo_hit;
    logic enter;
    logic irq_set;

    assign abort   = cfg_abort_i | ~cfg_enable_i;
    assign tmo_hit = tmo_en_q && (tmr_q == 16'd0);
    assign enter   = (state_d != state_q);
    // idx_q[AW] marks a full frame; the last write is on the bus in that same cycle
    assign irq_set = ((state_q == ST_NN) && (state_d == ST_DONE)) ||
                     ((state_d == ST_ERROR) && (state_q != ST_ERROR));

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (cfg_start_i) state_d = ST_CAPTURE;
                ST_CAPTURE: if (idx_q[AW]) state_d = ST_FFT;
                ST_FFT: begin
                    if (fft_done_i)   state_d = ST_NN;
                    else if (tmo_hit) state_d = ST_ERROR;
                end
                ST_NN: begin
                    if (nn_done_i)    state_d = ST_DONE;
                    else if (tmo_hit) state_d = ST_ERROR;
                end
                ST_DONE:    state_d = cfg_continuous_i ? ST_CAPTURE : ST_IDLE;
                ST_ERROR:   state_d = ST_ERROR;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        buf_we_d    = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        idx_d       = idx_q;
        dec_d       = dec_q;
        tmr_d       = tmr_q;
        tmo_en_d    = tmo_en_q;
        res_valid_d = res_valid_q;
        res_class_d = res_class_q;
        run_cnt_d   = run_cnt_q;
        err_d       = err_q;
        err_code_d  = err_code_q;

        if ((state_q == ST_CAPTURE) && smp_valid_i && !abort && !idx_q[AW]) begin
            if (dec_q == 8'd0) begin
                buf_we_d    = 1'b1;
                buf_addr_d  = idx_q[AW-1:0];
                buf_wdata_d = smp_data_i;
                idx_d       = idx_q + IDX_ONE;
                dec_d       = cfg_decimate_i;
            end else begin
                dec_d = dec_q - 8'd1;
            end
        end

        if (enter && (state_d == ST_CAPTURE)) begin
            idx_d = '0;
            dec_d = '0;
        end
        if ((state_q == ST_IDLE) && (state_d == ST_CAPTURE)) begin
            res_valid_d = 1'b0;
        end

        fft_start_d = (state_q == ST_CAPTURE) && (state_d == ST_FFT);
        nn_start_d  = (state_q == ST_FFT) && (state_d == ST_NN);

        // Each engine gets a fresh timer on entry; anywhere else it sits cleared
        if (enter && ((state_d == ST_FFT) || (state_d == ST_NN))) begin
            tmr_d    = cfg_timeout_i;
            tmo_en_d = (cfg_timeout_i != 16'd0);
        end else if (!enter && ((state_q == ST_FFT) || (state_q == ST_NN))) begin
            if (tmr_q != 16'd0) tmr_d = tmr_q - 16'd1;
        end else begin
            tmr_d    = '0;
            tmo_en_d = 1'b0;
        end

        if ((state_q == ST_NN) && (state_d == ST_DONE)) begin
            res_valid_d = 1'b1;
            res_class_d = nn_class_i;
            run_cnt_d   = run_cnt_q + 16'd1;
        end

        if ((state_d == ST_ERROR) && (state_q != ST_ERROR)) begin
            err_d      = 1'b1;
            err_code_d = (state_q == ST_FFT) ? 2'd1 : 2'd2;
        end
        if (abort) begin
            err_d      = 1'b0;
            err_code_d = 2'd0;
        end

        irq_d  = irq_set | (irq_q & ~irq_clr_i);
        busy_d = (state_d != ST_IDLE) && (state_d != ST_ERROR);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            idx_q       <= '0;
            dec_q       <= '0;
            tmr_q       <= '0;
            tmo_en_q    <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            fft_start_q <= 1'b0;
            nn_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_class_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            irq_q       <= 1'b0;
            run_cnt_q   <= '0;
        end else begin
            idx_q       <= idx_d;
            dec_q       <= dec_d;
            tmr_q       <= tmr_d;
            tmo_en_q    <= tmo_en_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            fft_start_q <= fft_start_d;
            nn_start_q  <= nn_start_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            irq_q       <= irq_d;
            run_cnt_q   <= run_cnt_d;
        end
    end

    assign buf_we_o       = buf_we_q;
    assign buf_addr_o     = buf_addr_q;
    assign buf_wdata_o    = buf_wdata_q;
    assign fft_start_o    = fft_start_q;
    assign nn_start_o     = nn_start_q;
    assign busy_o         = busy_q;
    assign state_o        = state_q;
    assign result_valid_o = res_valid_q;
    assign result_class_o = res_class_q;
    assign err_o          = err_q;
    assign err_code_o     = err_code_q;
    assign irq_o          = irq_q;
    assign run_count_o    = run_cnt_q;

endmodule

// File: doc/senseedge_run_sequencer.md
# senseedge_run_sequencer

Run sequencer for the SenseEdge predictive-maintenance datapath. It captures a frame of decimated sensor samples into the shared sample buffer, then launches the hardware FFT and the neural-network engine in turn, and latches the resulting class. It reports status and raises an interrupt for the management SoC. It sits between the Wishbone register file (which drives `cfg_*`) and the FFT/NN engines inside `senseedge_top`.

## Interface
Parameters:
- `N_SAMPLES`, 256: frame length; power of two, 16..1024.
- `SAMPLE_W`, 16: sample width.
- `AW`, `$clog2(N_SAMPLES)`: buffer address width.

Ports:
- `wb_clk_i` in 1: single clock for the whole block.
- `wb_rst_n_i` in 1: reset, asynchronous, active-low.
- `cfg_enable_i` in 1: level enable; dropping it aborts any run.
- `cfg_continuous_i` in 1: 1 = start a new frame automatically after each result.
- `cfg_start_i` in 1: one-cycle start pulse.
- `cfg_abort_i` in 1: one-cycle abort pulse.
- `cfg_decimate_i` in 8: keep 1 of every (value+1) valid samples.
- `cfg_timeout_i` in 16: engine timeout in cycles; 0 = disabled.
- `smp_valid_i` in 1: sample strobe.
- `smp_data_i` in SAMPLE_W: sample value.
- `buf_we_o` out 1: buffer write enable.
- `buf_addr_o` out AW: buffer write address.
- `buf_wdata_o` out SAMPLE_W: buffer write data.
- `fft_start_o` out 1: FFT start pulse.
- `fft_done_i` in 1: FFT done pulse.
- `nn_start_o` out 1: NN start pulse.
- `nn_done_i` in 1: NN done pulse.
- `nn_class_i` in 4: NN class, valid with `nn_done_i`.
- `irq_clr_i` in 1: clears `irq_o`.
- `busy_o` out 1: high whenever the state is not IDLE and not ERROR.
- `state_o` out 3: current state encoding.
- `result_valid_o` out 1: `result_class_o` holds a valid result.
- `result_class_o` out 4: latched class.
- `err_o` out 1: error flag.
- `err_code_o` out 2: 1 = FFT timeout, 2 = NN timeout.
- `irq_o` out 1: sticky interrupt.
- `run_count_o` out 16: number of completed runs.

## Operation
- States: IDLE=0, CAPTURE=1, FFT=2, NN=3, DONE=4, ERROR=5. All outputs are registered.
- **Abort.** `cfg_abort_i`, or `cfg_enable_i`=0, forces the next state to IDLE from any state. This has the highest priority.
  - Abort clears the `err_*` and timeout logic.
  - It leaves the result, IRQ and count untouched.
  - No further `buf_we_o`, `fft_start_o` or `nn_start_o` is issued.
- **IDLE.**
  - `cfg_start_i` with `cfg_enable_i`=1 moves to CAPTURE. It clears `result_valid_o`, the sample index and the decimation counter.
  - `cfg_start_i` in any other state is ignored.
- **CAPTURE.**
  - Each `smp_valid_i` advances the decimation counter. A sample is accepted when the counter is 0; the counter reloads to `cfg_decimate_i` on acceptance.
  - An accepted sample produces `buf_we_o`=1 on the next cycle, with `buf_addr_o` = index and `buf_wdata_o` = sample. The index then increments.
  - After write index N_SAMPLES-1 the state moves to FFT. `fft_start_o` pulses for exactly one cycle on entry.
  - `smp_valid_i` outside CAPTURE is ignored.
- **FFT.**
  - On entry the timer loads `cfg_timeout_i`, then decrements once per cycle.
  - `fft_done_i` moves to NN, with a one-cycle `nn_start_o` pulse on entry.
  - If the timer reaches 0 first (and `cfg_timeout_i` is not 0), the state moves to ERROR with code 1.
  - If done and expiry fall in the same cycle, done wins.
- **NN.**
  - The timer behaves the same as in FFT; expiry goes to ERROR with code 2.
  - `nn_done_i` moves to DONE. It latches `nn_class_i`, sets `result_valid_o`, increments `run_count_o` (wraps at 16 bits) and sets `irq_o`.
- **DONE.** Lasts one cycle. The next state is CAPTURE if `cfg_continuous_i`=1, otherwise IDLE. A continuous rerun keeps `result_valid_o`=1 and resets the sample index.
- **ERROR.** Sets `err_o`=1 and `irq_o`. The block stays in ERROR until an abort or `cfg_enable_i`=0, then returns to IDLE with `err_o` and `err_code_o` cleared.
- **Stray done pulses.** `fft_done_i` or `nn_done_i` received in the wrong state is ignored.
- **IRQ.** `irq_o` stays set until `irq_clr_i`. If a set and a clear happen in the same cycle, the set wins.

## Timing
- Reset values: state IDLE, all outputs 0.
- `cfg_start_i` at cycle t gives `state_o`=1 and `busy_o`=1 at t+1.
- An accepted sample at cycle t gives its buffer write at t+1.
- The last buffer write at cycle t gives `fft_start_o` at t+1.
- `fft_done_i` at t gives `nn_start_o` at t+1.
- `nn_done_i` at t gives `result_*`, `irq_o` and the count update at t+1 (state DONE), then IDLE or CAPTURE at t+2.
- With decimation 0 and samples on every cycle, a frame takes N_SAMPLES+1 cycles from the first sample to `fft_start_o`.
- Timeout: with `cfg_timeout_i`=T and no done, ERROR is entered T+1 cycles after the start pulse.
- Abort at t gives IDLE at t+1.

## Test plan
- Basic run: N=16, decimate 0, 16 back-to-back samples with values 0..15.
  - Expect `buf_addr_o`/`buf_wdata_o` = 0..15 in sequence and `fft_start_o` one cycle after the last write.
  - Then drive `fft_done_i`, then `nn_done_i` with class 7. Expect `result_class_o`=7, `irq_o`=1, `run_count_o`=1, return to IDLE.
- Decimation: `cfg_decimate_i`=3 with 64 samples. Expect exactly 16 writes, containing samples 0, 4, 8, …, 60.
- Timeouts:
  - `cfg_timeout_i`=10 with no `fft_done_i`: expect ERROR with `err_code_o`=1 and `irq_o` set. Then drop `cfg_enable_i` and expect IDLE with `err_o`=0.
  - Repeat with a timeout in NN: expect code 2.
  - `cfg_timeout_i`=0: expect no timeout.
- Abort mid-capture after 5 samples: expect IDLE the next cycle and no further writes. A restart begins again at address 0.
- Continuous mode over 3 runs: expect `run_count_o`=3 and `result_valid_o` continuously high after the first run. `irq_clr_i` asserted in the same cycle as a new result leaves `irq_o`=1.
- Stray pulses: `fft_done_i` during CAPTURE and `nn_done_i` during FFT must cause no state change. Reset asserted mid-NN must return every output to 0 immediately.
